// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked ALU with registered result/flags and iterative MUL.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] regB,
  input  logic [OPW-1:0]   pgmOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluOut,
  output logic             geFlg,
  output logic             neFlg,
  output logic             zFlg,
  output logic             cFlg
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LSL = 4'd5;
  localparam logic [3:0] OP_RXR = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_LSR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 rst_seen_q;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ge_q, ge_d, ne_q, ne_d, z_q, z_d, c_q, c_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [3:0]           op;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, upd_c, upd_cmp;
  logic                 shift_oob;
  logic [2*WIDTH-1:0]   mul_step;
  logic                 accept;

  generate
    if (OPW > 4) begin : g_unused_op
      logic unused_op_bits;
      assign unused_op_bits = ^pgmOp[OPW-1:4];
    end
  endgenerate

  // Held low for one cycle after any reset edge, so it reads 0 while reset is applied.
  assign in_ready  = !rst_seen_q &&
                     ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign out_valid = (state_q == DONE);
  assign aluOut    = result_q;
  assign geFlg     = ge_q;
  assign neFlg     = ne_q;
  assign zFlg      = z_q;
  assign cFlg      = c_q;

  always_comb begin
    op        = pgmOp[3:0];
    sum       = {1'b0, regA} + {1'b0, regB};
    shift_oob = (regB >= WIDTH'(WIDTH));
    alu_res   = regB;
    alu_c     = 1'b0;
    upd_c     = 1'b0;
    upd_cmp   = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; upd_c = 1'b1; end
      OP_AND: alu_res = regA & regB;
      OP_SUB: begin alu_res = regA - regB; alu_c = (regA >= regB); upd_c = 1'b1; end
      OP_ORR: alu_res = regA | regB;
      OP_XOR: alu_res = regA ^ regB;
      OP_LSL: alu_res = shift_oob ? '0 : (regA << regB);
      OP_LSR: alu_res = shift_oob ? '0 : (regA >> regB);
      OP_RXR: alu_res = {{(WIDTH-1){1'b0}}, ^regB};
      OP_CMP: begin alu_res = regA - regB; upd_cmp = 1'b1; end
      default: alu_res = regB;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ge_d     = ge_q;
    ne_d     = ne_q;
    z_d      = z_q;
    c_d      = c_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    accept   = in_valid && in_ready;
    mul_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: ;
      BUSY: begin
        acc_d    = mul_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        // The last partial product is folded in on the same edge that enters DONE.
        if (cnt_q == CNT_W'(1)) begin
          result_d = mul_step[WIDTH-1:0];
          c_d      = |mul_step[2*WIDTH-1:WIDTH];
          z_d      = (mul_step[WIDTH-1:0] == '0);
          state_d  = DONE;
        end
      end
      DONE: if (out_ready && !in_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (op == OP_MUL) begin
        mcand_d  = {{WIDTH{1'b0}}, regA};
        mplier_d = regB;
        acc_d    = '0;
        cnt_d    = CNT_W'(WIDTH);
        state_d  = BUSY;
      end else begin
        result_d = alu_res;
        z_d      = (alu_res == '0);
        if (upd_c) c_d = alu_c;
        if (upd_cmp) begin
          ge_d = ($signed(regA) >= $signed(regB));
          ne_d = (regA != regB);
        end
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rst_seen_q <= 1'b1;
      result_q   <= '0;
      ge_q       <= 1'b0;
      ne_q       <= 1'b0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rst_seen_q <= 1'b0;
      result_q   <= result_d;
      ge_q       <= ge_d;
      ne_q       <= ne_d;
      z_q        <= z_d;
      c_q        <= c_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Directed self-checking bench for alu_seq (WIDTH=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] regA, regB;
  logic [3:0] pgmOp;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] aluOut;
  logic       geFlg, neFlg, zFlg, cFlg;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8), .OPW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .regA(regA), .regB(regB), .pgmOp(pgmOp), .out_valid(out_valid),
    .out_ready(out_ready), .aluOut(aluOut), .geFlg(geFlg), .neFlg(neFlg),
    .zFlg(zFlg), .cFlg(cFlg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {ge, ne, z, c}.
  task automatic chk_flags(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, geFlg, neFlg, zFlg, cFlg}, {28'd0, exp});
  endtask

  // Issue one op from IDLE; leaves the DUT in DONE with out_ready low.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    regA = a; regB = b; pgmOp = op; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    regA = 8'h00; regB = 8'h00; pgmOp = 4'h0;

    // Reset state
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_aluOut", {24'd0, aluOut}, 32'h00);
    chk_flags("rst_flags", 4'b0000);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD with carry, then AND holding carry
    issue(8'hF0, 8'h20, 4'd0);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_res", {24'd0, aluOut}, 32'h10);
    chk_flags("add_flags", 4'b0001);
    release_result();
    chk("add_drained", {31'd0, out_valid}, 32'd0);

    issue(8'h0F, 8'hF0, 4'd1);
    chk("and_res", {24'd0, aluOut}, 32'h00);
    chk_flags("and_flags", 4'b0011);
    release_result();

    issue(8'h0F, 8'hA0, 4'd3);
    chk("orr_res", {24'd0, aluOut}, 32'hAF);
    chk_flags("orr_flags", 4'b0001);
    release_result();

    // Signed compare
    issue(8'h80, 8'h01, 4'd7);
    chk("cmp1_res", {24'd0, aluOut}, 32'h7F);
    chk_flags("cmp1_flags", 4'b0101);
    release_result();

    issue(8'h05, 8'h05, 4'd7);
    chk("cmp2_res", {24'd0, aluOut}, 32'h00);
    chk_flags("cmp2_flags", 4'b1011);
    release_result();

    issue(8'h05, 8'h03, 4'd4);
    chk("xor_res", {24'd0, aluOut}, 32'h06);
    chk_flags("xor_flags", 4'b1001);
    release_result();

    issue(8'h03, 8'h05, 4'd2);
    chk("sub_res", {24'd0, aluOut}, 32'hFE);
    chk_flags("sub_flags", 4'b1000);
    release_result();

    // MUL 0x13 x 0x0E = 0x010A; result appears 9 cycles after the accept cycle
    issue(8'h13, 8'h0E, 4'd9);
    regA = 8'hFF; regB = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mul_busy_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk("mul_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_res", {24'd0, aluOut}, 32'h0A);
    chk_flags("mul_flags", 4'b1001);
    chk("mul_hold_in_ready", {31'd0, in_ready}, 32'd0);
    release_result();

    // Shifts, reduction-XOR, pass-through
    issue(8'h81, 8'h01, 4'd5);
    chk("lsl1_res", {24'd0, aluOut}, 32'h02);
    release_result();
    issue(8'h81, 8'h07, 4'd8);
    chk("lsr7_res", {24'd0, aluOut}, 32'h01);
    release_result();
    issue(8'h81, 8'h08, 4'd5);
    chk("lsl8_res", {24'd0, aluOut}, 32'h00);
    chk_flags("lsl8_flags", 4'b1011);
    release_result();
    issue(8'h81, 8'h09, 4'd8);
    chk("lsr9_res", {24'd0, aluOut}, 32'h00);
    release_result();
    issue(8'h55, 8'h07, 4'd6);
    chk("rxr_res", {24'd0, aluOut}, 32'h01);
    release_result();
    issue(8'h12, 8'h34, 4'hF);
    chk("pass_res", {24'd0, aluOut}, 32'h34);
    chk_flags("pass_flags", 4'b1001);
    release_result();

    // Backpressure: stall 5 cycles with a new op already offered
    issue(8'h01, 8'h02, 4'd0);
    regA = 8'h10; regB = 8'h01; pgmOp = 4'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_res", {24'd0, aluOut}, 32'h03);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("done_in_ready_comb", {31'd0, in_ready}, 32'd1);
    tick();
    chk("b2b0_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b0_res", {24'd0, aluOut}, 32'h11);
    regA = 8'h20; regB = 8'h02;
    tick();
    chk("b2b1_res", {24'd0, aluOut}, 32'h22);
    regA = 8'h30; regB = 8'h03;
    tick();
    chk("b2b2_res", {24'd0, aluOut}, 32'h33);
    regA = 8'hFF; regB = 8'h45;
    tick();
    chk("b2b3_res", {24'd0, aluOut}, 32'h44);
    chk_flags("b2b3_flags", 4'b1001);
    in_valid = 1'b0;
    tick();
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Reset in the third BUSY cycle of a MUL
    issue(8'h13, 8'h0E, 4'd9);
    tick();
    tick();
    chk("mid_mul_busy", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    tick();
    chk("mul_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mul_rst_res", {24'd0, aluOut}, 32'h00);
    chk_flags("mul_rst_flags", 4'b0000);
    chk("mul_rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("mul_rst_release", {31'd0, in_ready}, 32'd1);
    chk("mul_rst_idle_valid", {31'd0, out_valid}, 32'd0);

    // Full MUL after reset: 0x0F x 0x11 = 0x00FF
    issue(8'h0F, 8'h11, 4'd9);
    for (int i = 0; i < 8; i++) tick();
    chk("mul2_valid", {31'd0, out_valid}, 32'd1);
    chk("mul2_res", {24'd0, aluOut}, 32'hFF);
    chk_flags("mul2_flags", 4'b0000);
    release_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
